// File: rtl/com_write.sv
// Reply-frame writer: fills the Ethernet TX RAM and hands off to the transmitter.
// Define COM_WRITE_CHK_EN to append an XOR checksum byte over bytes 2..7.
module com_write #(
  parameter logic [7:0] RAM_ADDR_INIT = 8'h00,
  parameter logic [7:0] HEAD0         = 8'h55,
  parameter logic [7:0] HEAD1         = 8'hAA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fs_write,
  output logic        fd_write,
  output logic        fs_eth_write,
  input  logic        fd_eth_write,
  input  logic [3:0]  write_btype,
  input  logic [15:0] com_stat,
  input  logic [15:0] com_cmd,
  output logic [7:0]  ram_txa,
  output logic [7:0]  ram_txd,
  output logic        ram_txen
);

`ifdef COM_WRITE_CHK_EN
  localparam logic [7:0] NUM = 8'd9;
`else
  localparam logic [7:0] NUM = 8'd8;
`endif

  localparam logic [7:0] MAIN_IDLE  = 8'h01;
  localparam logic [7:0] MAIN_WAIT  = 8'h02;
  localparam logic [7:0] WRITE_IDLE = 8'h04;
  localparam logic [7:0] WRITE_DATA = 8'h08;
  localparam logic [7:0] WRITE_TAKE = 8'h10;
  localparam logic [7:0] WRITE_WORK = 8'h20;
  localparam logic [7:0] WRITE_DONE = 8'h40;

  logic [7:0]  state;
  logic [7:0]  state_nx;
  logic [7:0]  num;
  logic [7:0]  seq;
  logic [7:0]  byte_nx;
  logic [3:0]  btype;
  logic [15:0] stat;
  logic [15:0] cmd;
  logic        in_data;

`ifdef COM_WRITE_CHK_EN
  logic [7:0]  chk;
`endif

  assign in_data = (state == WRITE_DATA);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MAIN_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = MAIN_IDLE;
    case (state)
      MAIN_IDLE:  state_nx = MAIN_WAIT;
      MAIN_WAIT:  state_nx = fs_write ? WRITE_IDLE : MAIN_WAIT;
      WRITE_IDLE: state_nx = WRITE_DATA;
      WRITE_DATA: state_nx = (num >= NUM - 8'd1) ? WRITE_TAKE
                                                 : WRITE_DATA;
      WRITE_TAKE: state_nx = WRITE_WORK;
      WRITE_WORK: state_nx = fd_eth_write ? WRITE_DONE : WRITE_WORK;
      WRITE_DONE: state_nx = fs_write ? WRITE_DONE : MAIN_IDLE;
      default:    state_nx = MAIN_IDLE;
    endcase
  end

  always_comb begin
    fs_eth_write = (state == WRITE_WORK);
    fd_write     = (state == WRITE_DONE);
  end

  always_comb begin
    byte_nx = 8'h00;
    case (num)
      8'd0: byte_nx = HEAD0;
      8'd1: byte_nx = HEAD1;
      8'd2: byte_nx = {4'h0, btype};
      8'd3: byte_nx = stat[15:8];
      8'd4: byte_nx = stat[7:0];
      8'd5: byte_nx = cmd[15:8];
      8'd6: byte_nx = cmd[7:0];
      8'd7: byte_nx = seq;
`ifdef COM_WRITE_CHK_EN
      8'd8: byte_nx = chk;
`endif
      default: byte_nx = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num <= 8'd0;
    end else if (in_data) begin
      num <= num + 8'd1;
    end else begin
      num <= 8'd0;
    end
  end

  // Inputs are frozen for the whole frame once WRITE_IDLE is passed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btype <= 4'h0;
      stat  <= 16'h0000;
      cmd   <= 16'h0000;
    end else if (state == MAIN_IDLE) begin
      btype <= 4'h0;
      stat  <= 16'h0000;
      cmd   <= 16'h0000;
    end else if (state == WRITE_IDLE) begin
      btype <= write_btype;
      stat  <= com_stat;
      cmd   <= com_cmd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq <= 8'h00;
    end else if (state == WRITE_WORK && fd_eth_write) begin
      seq <= seq + 8'h01;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_txa  <= RAM_ADDR_INIT;
      ram_txd  <= 8'h00;
      ram_txen <= 1'b0;
    end else if (in_data) begin
      ram_txa  <= RAM_ADDR_INIT + num;
      ram_txd  <= byte_nx;
      ram_txen <= 1'b1;
    end else begin
      ram_txa  <= RAM_ADDR_INIT;
      ram_txd  <= 8'h00;
      ram_txen <= 1'b0;
    end
  end

`ifdef COM_WRITE_CHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk <= 8'h00;
    end else if (state == WRITE_IDLE) begin
      chk <= 8'h00;
    end else if (in_data && num >= 8'd2 && num <= 8'd7) begin
      chk <= chk ^ byte_nx;
    end
  end
`endif

endmodule
